// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encodings,
// default operand width and the counter width helper.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit-position counter must hold 0..WIDTH
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus of serial_add_ctrl.
// SUB exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             SUB;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             Cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, A, B, Cin, SUB, input busy, done, SUM, Cout);
  modport slave  (input start, A, B, Cin, SUB, output busy, done, SUM, Cout);
`else
  modport master (output start, A, B, Cin, input busy, done, SUM, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, SUM, Cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// 1-bit full adder cell shared across all bit positions.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic SUM,
  output logic Cout
);

  assign SUM  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell is stepped over WIDTH
// cycles, LSB first, with the carry held in a flip-flop between bits.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds SUB, A-B via ~B + 1).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave io_bus
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [1:0]       w_state_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;
  logic [WIDTH-1:0] w_sum_shift;

  // Shared bit cell
  full_adder u_fa (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Cin  (r_carry),
    .SUM  (w_fa_sum),
    .Cout (w_fa_cout)
  );

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1; Cin is ignored when SUB is set
  assign w_b_load     = io_bus.SUB ? ~io_bus.B : io_bus.B;
  assign w_carry_load = io_bus.SUB | io_bus.Cin;
`else
  assign w_b_load     = io_bus.B;
  assign w_carry_load = io_bus.Cin;
`endif

  // New sum bit enters at the MSB; after WIDTH steps the register holds the result
  assign w_sum_shift = WIDTH'({w_fa_sum, r_sum_sh} >> 1);

  // Next-state and registered-output decode; encoding 2'd3 behaves as IDLE
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_step      = 1'b1;
        w_last      = (r_cnt == LAST_CNT);
        w_state_nxt = w_last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        // The edge leaving DONE is the IDLE sampling edge, so a held start
        // re-accepts there and throughput is one operation per WIDTH+1 cycles
        w_accept    = io_bus.start;
        w_state_nxt = io_bus.start ? ST_RUN : ST_IDLE;
      end
      default: begin
        w_accept    = io_bus.start;
        w_state_nxt = io_bus.start ? ST_RUN : ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Operand capture, serial stepping and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= io_bus.A;
      r_b_sh  <= w_b_load;
      r_carry <= w_carry_load;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_carry  <= w_fa_cout;
      r_sum_sh <= w_sum_shift;
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_sum_shift;
        r_cout <= w_fa_cout;
      end
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.SUM  = r_sum;
  assign io_bus.Cout = r_cout;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It sequences a single 1-bit `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands, and keeps the carry in a flip-flop between bits. It trades latency for area in arithmetic paths where one adder cell is shared across all bit positions. Operation uses a start/done handshake, and results are held until the next accepted start.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Legal range is ≥ 1.

Ports:
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `A`, input, WIDTH: operand A. Captured on the accepting edge.
- `B`, input, WIDTH: operand B. Captured on the accepting edge.
- `Cin`, input, 1: carry-in. Captured on the accepting edge.
- `SUB`, input, 1: subtract select. Present only with `SERIAL_ADD_SUB_EN`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle completion pulse.
- `SUM`, output, WIDTH: registered result.
- `Cout`, output, 1: registered final carry.

## Operation
States are IDLE, RUN and DONE.

**IDLE**
- When `start`=1: load `a_sh`←A, `b_sh`←B, `carry`←Cin, `cnt`←0, then go to RUN.
- Otherwise remain in IDLE.

**RUN**
- Full-adder inputs are `a_sh[0]`, `b_sh[0]` and `carry`.
- Every edge:
  - `carry`←adder Cout.
  - The adder SUM bit shifts into the MSB of `sum_sh`.
  - `a_sh` and `b_sh` shift right by one.
  - `cnt`++.
- When `cnt`==WIDTH-1, on that same edge:
  - `SUM`←{adder SUM bit, `sum_sh[WIDTH-1:1]`}.
  - `Cout`←adder Cout.
  - Go to DONE.

**DONE**
- `done`=1 for this single cycle, then go unconditionally to IDLE.

**General rules**
- `cnt` width is $clog2(WIDTH+1).
- Result is A+B+Cin mod 2^WIDTH. `Cout` is bit WIDTH of that sum.
- `start` in RUN or DONE is ignored. No queuing.
- Changes on A, B or Cin after acceptance have no effect on the operation in flight.
- `SUM` and `Cout` change only on the final RUN edge. They hold between operations.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset value of all outputs is 0: `busy`, `done`, `SUM`, `Cout`.
- Reset also clears all internal state, and the state machine returns to IDLE.
- Reset asserted mid-RUN aborts the operation. No `done` is produced.
- Label the edge that accepts `start` as edge 0.
  - `busy`=1 from after edge 0 through edge WIDTH.
  - `SUM`, `Cout` and `done` are valid after edge WIDTH.
  - `done` falls at edge WIDTH+1, which is also when IDLE is re-entered.
- Latency from accepting edge to `done` is WIDTH cycles.
- If `start` is held high continuously, it is re-accepted at edge WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- `done` and `busy` are never high together.

## Configuration
Macro: `SERIAL_ADD_SUB_EN`.
- **Defined:**
  - Port `SUB` exists and is captured with the operands.
  - When SUB=1: load `b_sh`←~B and `carry`←1. Cin is ignored.
  - The result is A−B mod 2^WIDTH.
  - `Cout`=1 iff A≥B (unsigned).
- **Undefined:**
  - No `SUB` port.
  - Add only, with identical behaviour to SUB=0.

## Structure
- Shared package/include holds:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- State encoding 2'd3 is unreachable. It decodes to IDLE.
- One sub-module: the existing `full_adder` (A, B, Cin, SUM, Cout), instantiated once as the shared bit cell.
- Everything else lives in this module: state register, counter, three shift registers, carry flip-flop, output registers.

## Test plan
All scenarios use WIDTH=8.
- **Basic add:** A=8'h3C, B=8'h0F, Cin=0, start pulse.
  - Expect SUM=8'h4B and Cout=0.
  - `done` high exactly 8 cycles after the accepting edge, for one cycle.
  - `busy` high for 8 cycles.
- **Wrap and carry-in:**
  - A=8'hFF, B=8'h01, Cin=0 → SUM=8'h00, Cout=1.
  - A=8'h00, B=8'h00, Cin=1 → SUM=8'h01, Cout=0.
- **Input isolation:** start with A=8'h10, B=8'h20. At cycle 3, drive A=8'hFF, B=8'hFF and pulse start.
  - Expect SUM=8'h30.
  - Only one `done`.
  - Second start ignored.
- **Back-to-back:** start held high with operands 8'h01+8'h01, then 8'h80+8'h80.
  - `done` pulses 9 cycles apart.
  - Results 8'h02/Cout=0, then 8'h00/Cout=1.
  - `SUM` stable between pulses.
- **Reset mid-op:** assert rst_n=0 at cycle 4 of RUN.
  - All outputs 0 immediately (asynchronous).
  - No `done`.
  - After release, a fresh A=8'h05, B=8'h03 gives 8'h08.
- **Subtract** (with `SERIAL_ADD_SUB_EN` defined):
  - SUB=1, A=8'h05, B=8'h07 → SUM=8'hFE, Cout=0.
  - SUB=1, A=8'h07, B=8'h05 → SUM=8'h02, Cout=1.
